ftsd_scan_ctrl: RTL and testbench

//  Parametrised multiplexed seven-segment scanner: owns its own refresh prescaler and digit counter, snapshots
//  hex digit values once per frame (tear-free), decodes to segments with per-digit DP/blank, drives one-hot

---
 rtl/ftsd_scan_ctrl_pkg.sv | 27 ++
 rtl/ftsd_scan_ctrl_if.sv | 22 ++
 rtl/ftsd_scan_ctrl_hex2seg.sv | 33 +++
 rtl/ftsd_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_ftsd_scan_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/ftsd_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scanner: active-low segment codes {a..g,dp}, dp off.
package ftsd_scan_ctrl_pkg;

  localparam logic [7:0] SEG_0   = 8'b0000_0011;
  localparam logic [7:0] SEG_1   = 8'b1001_1111;
  localparam logic [7:0] SEG_2   = 8'b0010_0101;
  localparam logic [7:0] SEG_3   = 8'b0000_1101;
  localparam logic [7:0] SEG_4   = 8'b1001_1001;
  localparam logic [7:0] SEG_5   = 8'b0100_1001;
  localparam logic [7:0] SEG_6   = 8'b0100_0001;
  localparam logic [7:0] SEG_7   = 8'b0001_1111;
  localparam logic [7:0] SEG_8   = 8'b0000_0001;
  localparam logic [7:0] SEG_9   = 8'b0000_1001;
  localparam logic [7:0] SEG_A   = 8'b0001_0001;
  localparam logic [7:0] SEG_B   = 8'b1100_0001;
  localparam logic [7:0] SEG_C   = 8'b0110_0011;
  localparam logic [7:0] SEG_D   = 8'b1000_0101;
  localparam logic [7:0] SEG_E   = 8'b0110_0001;
  localparam logic [7:0] SEG_F   = 8'b0111_0001;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Merge a decoded a..g pattern with an active-high dp request into the active-low pin byte.
  function automatic logic [7:0] seg_with_dp(input logic [6:0] abcdefg, input logic dp);
    return {abcdefg, ~dp};
  endfunction

endpackage

// File: rtl/ftsd_scan_ctrl_if.sv
// Display bus between the application datapath (master) and the scanner (slave).
interface ftsd_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic [4*DIGITS-1:0]   digits_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
  logic [DIGITS-1:0]     ftsd_ctl;
  logic [7:0]            segment;
  logic                  frame_done;

  modport master (
    output en, digits_in, dp_in, blank_in,
    input  ftsd_ctl, segment, frame_done
  );

  modport slave (
    input  en, digits_in, dp_in, blank_in,
    output ftsd_ctl, segment, frame_done
  );
endinterface

// File: rtl/ftsd_scan_ctrl_hex2seg.sv
// Combinational hex nibble to active-low a..g segment pattern; decimal point handled by the caller.
module ftsd_hex2seg
  import ftsd_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Hex lookup, top seven bits of each packed code.
  always_comb begin
    seg = SEG_OFF[7:1];
    case (hex)
      4'h0:    seg = SEG_0[7:1];
      4'h1:    seg = SEG_1[7:1];
      4'h2:    seg = SEG_2[7:1];
      4'h3:    seg = SEG_3[7:1];
      4'h4:    seg = SEG_4[7:1];
      4'h5:    seg = SEG_5[7:1];
      4'h6:    seg = SEG_6[7:1];
      4'h7:    seg = SEG_7[7:1];
      4'h8:    seg = SEG_8[7:1];
      4'h9:    seg = SEG_9[7:1];
      4'hA:    seg = SEG_A[7:1];
      4'hB:    seg = SEG_B[7:1];
      4'hC:    seg = SEG_C[7:1];
      4'hD:    seg = SEG_D[7:1];
      4'hE:    seg = SEG_E[7:1];
      4'hF:    seg = SEG_F[7:1];
      default: seg = SEG_OFF[7:1];
    endcase
  end

endmodule

// File: rtl/ftsd_scan_ctrl.sv
// Multiplexed seven-segment scanner with per-frame tear-free snapshot of digit values.
// Optional leading-zero blanking is enabled by defining FTSD_LZB_EN.
module ftsd_scan_ctrl
  import ftsd_scan_ctrl_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic   clk,
  input  logic   rst,
  ftsd_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

  logic [PW-1:0]         presc_r;
  logic [IW-1:0]         idx_r;
  logic [4*DIGITS-1:0]   dig_sh_r;
  logic [DIGITS-1:0]     dp_sh_r;
  logic [DIGITS-1:0]     blank_sh_r;
  logic                  first_r;
  logic [DIGITS-1:0]     ctl_r;
  logic [7:0]            seg_r;
  logic                  fd_r;

  logic                  tick_s;
  logic                  wrap_s;
  logic [DIGITS-1:0]     lzb_s;
  logic [3:0]            sel_dig_s;
  logic                  sel_dp_s;
  logic                  sel_blank_s;
  logic [DIGITS-1:0]     ctl_s;
  logic [6:0]            seg7_s;
  logic [7:0]            seg_s;

  assign tick_s = bus.en & (presc_r == PRESC_MAX);
  assign wrap_s = tick_s & (idx_r == IDX_MAX);

`ifdef FTSD_LZB_EN
  logic zero_above_s;

  // Leading-zero mask: digit k dark while it and every higher shadow digit are zero.
  always_comb begin
    lzb_s        = {DIGITS{1'b0}};
    zero_above_s = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above_s = zero_above_s & (dig_sh_r[4*k +: 4] == 4'h0);
      lzb_s[k]     = zero_above_s;
    end
  end
`else
  assign lzb_s = {DIGITS{1'b0}};
`endif

  // Select the shadow fields of the digit currently addressed by idx and build its enable.
  always_comb begin
    sel_dig_s   = 4'h0;
    sel_dp_s    = 1'b0;
    sel_blank_s = 1'b0;
    ctl_s       = {DIGITS{1'b1}};
    for (int k = 0; k < DIGITS; k++) begin
      sel_dig_s   = sel_dig_s | (dig_sh_r[4*k +: 4] & {4{idx_r == IW'(k)}});
      sel_dp_s    = sel_dp_s | (dp_sh_r[k] & (idx_r == IW'(k)));
      sel_blank_s = sel_blank_s | ((blank_sh_r[k] | lzb_s[k]) & (idx_r == IW'(k)));
      ctl_s[k]    = (idx_r != IW'(k));
    end
  end

  ftsd_hex2seg u_hex2seg (
    .hex (sel_dig_s),
    .seg (seg7_s)
  );

  assign seg_s = seg_with_dp(sel_blank_s ? 7'h7F : seg7_s, sel_dp_s);

  // Refresh prescaler, digit index and per-frame shadow snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r    <= {PW{1'b0}};
      idx_r      <= {IW{1'b0}};
      dig_sh_r   <= {(4*DIGITS){1'b0}};
      dp_sh_r    <= {DIGITS{1'b0}};
      blank_sh_r <= {DIGITS{1'b0}};
      first_r    <= 1'b1;
    end else begin
      if (bus.en) begin
        presc_r <= (presc_r == PRESC_MAX) ? {PW{1'b0}} : presc_r + PW'(1);
      end
      if (tick_s) begin
        idx_r <= (idx_r == IDX_MAX) ? {IW{1'b0}} : idx_r + IW'(1);
      end
      // The very first edge out of reset loads shadows so the first frame is not all zeros.
      if (wrap_s | first_r) begin
        dig_sh_r   <= bus.digits_in;
        dp_sh_r    <= bus.dp_in;
        blank_sh_r <= bus.blank_in;
      end
      first_r <= 1'b0;
    end
  end

  // Registered pin stage, one clock behind idx; dark while disabled or in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_r <= {DIGITS{1'b1}};
      seg_r <= SEG_OFF;
      fd_r  <= 1'b0;
    end else begin
      fd_r <= wrap_s;
      if (bus.en) begin
        ctl_r <= ctl_s;
        seg_r <= seg_s;
      end else begin
        ctl_r <= {DIGITS{1'b1}};
        seg_r <= SEG_OFF;
      end
    end
  end

  assign bus.ftsd_ctl   = ctl_r;
  assign bus.segment    = seg_r;
  assign bus.frame_done = fd_r;

endmodule

// File: tb/tb_ftsd_scan_ctrl.sv
// Randomized bench for ftsd_scan_ctrl (DIGITS=4, SCAN_DIV=4) against a cycle-level behavioural model.
module tb_ftsd_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic r_rst;
  logic r_en;
  logic [15:0] r_dig;
  logic [3:0]  r_dp;
  logic [3:0]  r_bl;

  ftsd_if #(.DIGITS(ND)) bus ();

  assign bus.en        = r_en;
  assign bus.digits_in = r_dig;
  assign bus.dp_in     = r_dp;
  assign bus.blank_in  = r_bl;

  ftsd_scan_ctrl #(.DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk (clk),
    .rst (r_rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [6:0]  tab [16];
  int          m_presc, m_idx;
  logic        m_first;
  logic [15:0] m_sh_dig;
  logic [3:0]  m_sh_dp, m_sh_bl;
  logic [3:0]  exp_ctl;
  logic [7:0]  exp_seg;
  logic        exp_fd;

  task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic lead_zero(input int k);
`ifdef FTSD_LZB_EN
    return (k >= 1) && ((m_sh_dig >> (4 * k)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  // Advance one clock, update the model, then compare all outputs.
  task automatic step();
    logic tick, wrap, blk;
    logic [3:0] d;
    @(posedge clk);
    if (r_rst) begin
      m_presc = 0; m_idx = 0; m_first = 1'b1;
      m_sh_dig = 16'h0; m_sh_dp = 4'h0; m_sh_bl = 4'h0;
      exp_ctl = 4'hF; exp_seg = 8'hFF; exp_fd = 1'b0;
    end else begin
      tick = r_en && (m_presc == SD - 1);
      wrap = tick && (m_idx == ND - 1);
      if (r_en) begin
        exp_ctl = ~(4'b0001 << m_idx);
        d = 4'((m_sh_dig >> (4 * m_idx)) & 16'hF);
        blk = m_sh_bl[m_idx] | lead_zero(m_idx);
        exp_seg = {blk ? 7'h7F : tab[d], ~m_sh_dp[m_idx]};
      end else begin
        exp_ctl = 4'hF;
        exp_seg = 8'hFF;
      end
      exp_fd = wrap;
      if (r_en) m_presc = (m_presc + 1) % SD;
      if (tick) m_idx = (m_idx + 1) % ND;
      if (wrap || m_first) begin
        m_sh_dig = r_dig; m_sh_dp = r_dp; m_sh_bl = r_bl;
      end
      m_first = 1'b0;
    end
    #1;
    check_value("ctl", 16'(bus.ftsd_ctl), 16'(exp_ctl));
    check_value("seg", 16'(bus.segment), 16'(exp_seg));
    check_value("fd", 16'(bus.frame_done), 16'(exp_fd));
  endtask

  initial begin
    tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    m_presc = 0; m_idx = 0; m_first = 1'b1;
    m_sh_dig = 16'h0; m_sh_dp = 4'h0; m_sh_bl = 4'h0;
    r_rst = 1'b1; r_en = 1'b1; r_dig = 16'h1234; r_dp = 4'h0; r_bl = 4'h0;

    for (int i = 0; i < 3; i++) begin
      step();
      check_value("rst_ctl", 16'(bus.ftsd_ctl), 16'h000F);
      check_value("rst_seg", 16'(bus.segment), 16'h00FF);
      check_value("rst_fd", 16'(bus.frame_done), 16'h0000);
    end
    r_rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      step();
      if (i > 2 && exp_ctl == 4'b1110) check_value("lit4", 16'(bus.segment), 16'h0099);
    end

    for (int i = 0; i < 20 && m_idx != 1; i++) step();
    r_dig = 16'h5678;
    for (int i = 0; i < 40; i++) step();

    for (int i = 0; i < 30 && !(m_idx == 2 && m_presc == 1); i++) step();
    r_en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    r_en = 1'b1;
    for (int i = 0; i < 20; i++) step();

    r_dig = 16'h1234; r_dp = 4'b0010; r_bl = 4'b1000;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i > 20 && exp_ctl == 4'b1101) check_value("lit_dp", 16'(bus.segment), 16'h000C);
      if (i > 20 && exp_ctl == 4'b0111) check_value("lit_blank", 16'(bus.segment), 16'h00FF);
    end

    r_dig = 16'h0050; r_dp = 4'h0; r_bl = 4'h0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i > 20 && exp_ctl == 4'b1110) check_value("lit0", 16'(bus.segment), 16'h0003);
      if (i > 20 && exp_ctl == 4'b1101) check_value("lit5", 16'(bus.segment), 16'h0049);
`ifdef FTSD_LZB_EN
      if (i > 20 && exp_ctl == 4'b0111) check_value("lzb3", 16'(bus.segment), 16'h00FF);
`else
      if (i > 20 && exp_ctl == 4'b0111) check_value("nolzb3", 16'(bus.segment), 16'h0003);
`endif
    end

    for (int i = 0; i < 20 && m_idx != 2; i++) step();
    r_rst = 1'b1;
    step();
    check_value("mid_rst_ctl", 16'(bus.ftsd_ctl), 16'h000F);
    check_value("mid_rst_seg", 16'(bus.segment), 16'h00FF);
    r_rst = 1'b0;
    for (int i = 0; i < 20; i++) step();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19, 0) == 0) r_dig = 16'($urandom);
      if ($urandom_range(29, 0) == 0) r_dp = 4'($urandom);
      if ($urandom_range(29, 0) == 0) r_bl = 4'($urandom);
      if ($urandom_range(39, 0) == 0) r_en = ~r_en;
      if ($urandom_range(7, 0) == 0 && r_dig[15:8] != 8'h0) r_dig[15:8] = 8'h00;
      r_rst = ($urandom_range(299, 0) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
